// File: rtl/serial_alu_sequencer_if.sv
// ============================================================================
// Module      : serial_alu_sequencer_if
// Description : Control/datapath bundle between decode, the serial ALU
//               sequencer and the 1-bit ALU + operand shift registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_alu_sequencer_if #(
  parameter int WIDTH = 8
);
  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic            ena;
  logic            start;
  logic [2:0]      op;
  logic            res_bit;
  logic            cout;
  logic            busy;
  logic            ld_en;
  logic            sh_en;
  logic [IDXW-1:0] bit_idx;
  logic [2:0]      op_q;
  logic            inv_b;
  logic            cin;
  logic            wb_en;
  logic            done;
  logic            flag_z;
  logic            flag_c;

  // slave: the sequencer itself
  modport slave (
    input  ena, start, op, res_bit, cout,
    output busy, ld_en, sh_en, bit_idx, op_q, inv_b, cin, wb_en, done,
           flag_z, flag_c
  );

  // master: decode logic plus the ALU/shift-register datapath
  modport master (
    output ena, start, op, res_bit, cout,
    input  busy, ld_en, sh_en, bit_idx, op_q, inv_b, cin, wb_en, done,
           flag_z, flag_c
  );
endinterface

`default_nettype wire

// File: rtl/serial_alu_sequencer.sv
// ============================================================================
// Module      : serial_alu_sequencer
// Description : Control FSM for a 1-bit serial ALU: load, WIDTH LSB-first
//               shift cycles with carry/zero tracking, then write-back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  serial_alu_sequencer_if.slave bus
);

  localparam int              IDXW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_WB    = 2'd3
  } state_e;

  state_e          state_q,   state_d;
  logic [2:0]      opc_q,     opc_d;
  logic            carry_q,   carry_d;
  logic            z_acc_q,   z_acc_d;
  logic [IDXW-1:0] bit_idx_q, bit_idx_d;
  logic            flag_z_q,  flag_z_d;
  logic            flag_c_q,  flag_c_d;

  logic is_arith;
  assign is_arith = (opc_q == OP_ADD) || (opc_q == OP_SUB);

  // Every transition is qualified by ena so a frozen op resumes unchanged.
  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    carry_d   = carry_q;
    z_acc_d   = z_acc_q;
    bit_idx_d = bit_idx_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    if (bus.ena) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_LOAD;
            opc_d   = bus.op;
          end
        end
        S_LOAD: begin
          carry_d   = (opc_q == OP_SUB);
          z_acc_d   = 1'b1;
          bit_idx_d = '0;
          state_d   = S_SHIFT;
        end
        S_SHIFT: begin
          carry_d = is_arith ? bus.cout : 1'b0;
          z_acc_d = z_acc_q & ~bus.res_bit;
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
            state_d   = S_WB;
          end else begin
            bit_idx_d = bit_idx_q + IDXW'(1);
          end
        end
        S_WB: begin
          flag_z_d = z_acc_q;
          flag_c_d = is_arith ? carry_q : 1'b0;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      opc_q     <= '0;
      carry_q   <= 1'b0;
      z_acc_q   <= 1'b0;
      bit_idx_q <= '0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      carry_q   <= carry_d;
      z_acc_q   <= z_acc_d;
      bit_idx_q <= bit_idx_d;
      flag_z_q  <= flag_z_d;
      flag_c_q  <= flag_c_d;
    end
  end

  // Strobes are decodes of the state flop, gated so a frozen cycle does nothing.
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.ld_en   = bus.ena & (state_q == S_LOAD);
  assign bus.sh_en   = bus.ena & (state_q == S_SHIFT);
  assign bus.wb_en   = bus.ena & (state_q == S_WB);
  assign bus.done    = bus.ena & (state_q == S_WB);
  assign bus.bit_idx = bit_idx_q;
  assign bus.op_q    = opc_q;
  assign bus.inv_b   = (state_q != S_IDLE) & (opc_q == OP_SUB);
  assign bus.cin     = carry_q;
  assign bus.flag_z  = flag_z_q;
  assign bus.flag_c  = flag_c_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_alu_sequencer.sv
// ============================================================================
// Module      : tb_serial_alu_sequencer
// Description : Bench for serial_alu_sequencer with a behavioural 1-bit ALU
//               datapath and a result/flag scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_alu_sequencer;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  logic prev_z = 1'b0;
  logic prev_c = 1'b0;

  always #5 clk = ~clk;

  serial_alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

  serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural datapath: operand/result shift registers and a 1-bit ALU.
  logic [WIDTH-1:0] a_in, b_in, a_sr, b_sr, r_sr, wb_res;
  logic             bb;

  always_comb begin
    bb          = b_sr[0] ^ bus.inv_b;
    bus.res_bit = a_sr[0];
    bus.cout    = 1'b0;
    case (bus.op_q)
      3'b000, 3'b001: begin
        bus.res_bit = a_sr[0] ^ bb ^ bus.cin;
        bus.cout    = (a_sr[0] & bb) | (a_sr[0] & bus.cin) | (bb & bus.cin);
      end
      3'b010:  bus.res_bit = a_sr[0] & b_sr[0];
      3'b011:  bus.res_bit = a_sr[0] | b_sr[0];
      3'b100:  bus.res_bit = a_sr[0] ^ b_sr[0];
      default: bus.res_bit = a_sr[0];
    endcase
  end

  always @(posedge clk) begin
    if (bus.ld_en) begin
      a_sr <= a_in;
      b_sr <= b_in;
    end else if (bus.sh_en) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      r_sr <= {bus.res_bit, r_sr[WIDTH-1:1]};
    end
    if (bus.wb_en) wb_res <= r_sr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    exp_t e;
    case (op)
      3'b000:  s = {1'b0, a} + {1'b0, b};
      3'b001:  s = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
      3'b010:  s = {1'b0, a & b};
      3'b011:  s = {1'b0, a | b};
      3'b100:  s = {1'b0, a ^ b};
      default: s = {1'b0, a};
    endcase
    e.res = s[WIDTH-1:0];
    e.c   = (op == 3'b000 || op == 3'b001) ? s[WIDTH] : 1'b0;
    e.z   = (e.res == '0);
    return e;
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({bus.busy, bus.ld_en, bus.sh_en, bus.wb_en, bus.done, bus.inv_b,
                bus.cin, bus.flag_z, bus.flag_c, bus.op_q, bus.bit_idx});
  endfunction

  // One full op; optional 3-cycle ena freeze at stall_at and a start poke at poke_at.
  task automatic run_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input int stall_at, input int poke_at);
    int   cyc, idx, stall_left, exp_done;
    bit   stalled, seen_done;
    exp_t e;
    @(negedge clk);
    a_in = a; b_in = b; bus.op = op; bus.start = 1'b1;
    sb.push_back(ref_op(op, a, b));
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    check("ld_en_cycle1", 32'(bus.ld_en), 1);
    check("busy_cycle1", 32'(bus.busy), 1);
    check("op_q_latched", 32'(bus.op_q), 32'(op));
    check("flag_z_hold", 32'(bus.flag_z), 32'(prev_z));
    check("flag_c_hold", 32'(bus.flag_c), 32'(prev_c));
    idx = 0; stall_left = 0; stalled = 0; seen_done = 0;
    exp_done = WIDTH + 2 + ((stall_at >= 0) ? 3 : 0);
    while (cyc < 60 && !seen_done) begin
      @(negedge clk);
      cyc++;
      if (!stalled && stall_at >= 0 && bus.sh_en && 32'(bus.bit_idx) == stall_at) begin
        bus.ena = 1'b0; stalled = 1; stall_left = 3;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) bus.ena = 1'b1;
      end
      bus.start = (stalled && stall_left == 2) ||
                  (poke_at >= 0 && bus.ena && bus.busy && 32'(bus.bit_idx) == poke_at);
      #1;
      if (bus.ena) begin
        if (bus.sh_en) begin
          check("bit_idx", 32'(bus.bit_idx), 32'(idx));
          if (idx == 0) begin
            check("cin_first", 32'(bus.cin), 32'(op == 3'b001));
            check("inv_b_first", 32'(bus.inv_b), 32'(op == 3'b001));
          end
          idx++;
        end
        if (bus.done) begin
          seen_done = 1;
          check("done_cycle", 32'(cyc), 32'(exp_done));
          check("wb_with_done", 32'(bus.wb_en), 1);
          check("shift_count", 32'(idx), WIDTH);
        end
      end else begin
        check("frozen_strobes", 32'({bus.sh_en, bus.done, bus.wb_en}), 0);
      end
    end
    bus.start = 1'b0;
    if (!seen_done) check("done_timeout", 0, 1);
    @(negedge clk);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("result", 32'(wb_res), 32'(e.res));
      check("flag_z", 32'(bus.flag_z), 32'(e.z));
      check("flag_c", 32'(bus.flag_c), 32'(e.c));
      prev_z = e.z; prev_c = e.c;
    end
    check("idle_after", 32'(bus.busy), 0);
    @(negedge clk);
    check("no_restart", 32'(bus.busy), 0);
  endtask

  task automatic abort_op();
    int   dones;
    bit   hit;
    @(negedge clk);
    a_in = 8'h12; b_in = 8'h34; bus.op = 3'b000; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      if (bus.sh_en && bus.bit_idx == 3'd4) hit = 1;
    end
    check("abort_reached_idx4", 32'(hit), 1);
    rst_n = 1'b0;
    #1;
    check("abort_outs_zero", all_outs(), 0);
    prev_z = 1'b0; prev_c = 1'b0;
    @(negedge clk);
    check("abort_held_zero", all_outs(), 0);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done || bus.wb_en) dones++;
    end
    check("abort_no_done", 32'(dones), 0);
    check("abort_idle", 32'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; bus.ena = 1'b1; bus.start = 1'b1; bus.op = 3'b000;
    a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check("reset_outs_zero", all_outs(), 0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_idle", 32'(bus.busy), 0);
    check("reset_no_load", 32'(bus.ld_en), 0);

    run_op(3'b000, 8'h35, 8'h4A, -1, -1);
    run_op(3'b001, 8'h05, 8'h05, -1, -1);
    run_op(3'b000, 8'hFF, 8'h01, -1, -1);
    run_op(3'b100, 8'hF0, 8'h0F, -1, -1);
    run_op(3'b000, 8'h21, 8'h13,  3,  5);
    run_op(3'b110, 8'hA5, 8'h00, -1, -1);
    abort_op();
    run_op(3'b010, 8'hC3, 8'h3C, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
